gshare_bht: RTL and testbench

//  Parametrised gshare branch-history table; successor to the per-PC 2-bit BHT.

---
 rtl/gshare_bht.sv | 107 ++++++++++
 tb/tb_gshare_bht.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gshare_bht.sv
// gshare predictor: PC XOR speculative global history indexes a table of saturating counters.
// Prediction is combinational; updates land next cycle; mispredicts restore history from the checkpoint.
module gshare_bht #(
    parameter int INDEX_BITS = 8,
    parameter int CTR_BITS   = 2,
    parameter int GHR_LEN    = 8,
    parameter int PC_LSB     = 2
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  pred_valid_i,
    input  logic [31:0]           pred_pc_i,
    output logic                  pred_taken_o,
    output logic [INDEX_BITS-1:0] pred_idx_o,
    output logic [GHR_LEN-1:0]    pred_ghr_o,
    input  logic                  upd_valid_i,
    input  logic [INDEX_BITS-1:0] upd_idx_i,
    input  logic [GHR_LEN-1:0]    upd_ghr_i,
    input  logic                  upd_taken_i,
    input  logic                  upd_pred_i,
    output logic                  ready_o,
    output logic                  miss_predict_o,
    output logic [15:0]           miss_cnt_o
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [INDEX_BITS-1:0] ptr;
    logic [GHR_LEN-1:0]    ghr;
    logic [CTR_BITS-1:0]   ctr [DEPTH];
    logic [15:0]           miss_cnt;
    logic [CTR_BITS-1:0]   ctr_cur;
    logic [CTR_BITS-1:0]   ctr_next;
    logic [GHR_LEN-1:0]    ghr_spec;
    logic [GHR_LEN-1:0]    ghr_fix;
    logic                  run;
    logic                  miss;
    logic                  unused_bits;

    assign run  = (state == ST_RUN);
    assign miss = run & upd_valid_i & (upd_taken_i != upd_pred_i);

    assign pred_idx_o   = pred_pc_i[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr);
    assign pred_taken_o = run & ctr[pred_idx_o][CTR_BITS-1];
    assign pred_ghr_o   = ghr;
    assign ready_o      = run;
    assign miss_cnt_o   = miss_cnt;
    assign unused_bits  = ^{pred_pc_i, upd_ghr_i};

    generate
        if (GHR_LEN == 1) begin : g_ghr1
            assign ghr_spec = pred_taken_o;
            assign ghr_fix  = upd_taken_i;
        end else begin : g_ghrn
            assign ghr_spec = {ghr[GHR_LEN-2:0], pred_taken_o};
            assign ghr_fix  = {upd_ghr_i[GHR_LEN-2:0], upd_taken_i};
        end
    endgenerate

    always_comb begin
        ctr_cur  = ctr[upd_idx_i];
        ctr_next = ctr_cur;
        if (upd_taken_i) begin
            if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
        end else if (ctr_cur != '0) begin
            ctr_next = ctr_cur - 1'b1;
        end
    end

    // Single write port: the init sweep owns it until the table is ready.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            if (!run) begin
                ctr[ptr] <= CTR_WEAK;
            end else if (upd_valid_i) begin
                ctr[upd_idx_i] <= ctr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state          <= ST_INIT;
            ptr            <= '0;
            ghr            <= '0;
            miss_predict_o <= 1'b0;
            miss_cnt       <= '0;
        end else if (!run) begin
            ptr            <= ptr + 1'b1;
            miss_predict_o <= 1'b0;
            if (ptr == '1) state <= ST_RUN;
        end else begin
            miss_predict_o <= miss;
            // A resolved mispredict wins over a same-cycle speculative shift.
            if (miss) begin
                ghr <= ghr_fix;
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end else if (pred_valid_i) begin
                ghr <= ghr_spec;
            end
        end
    end
endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht: expectations are queued by the driver and popped by a negedge monitor.
module tb_gshare_bht;
    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [7:0]  pred_idx;
    logic [7:0]  pred_ghr;
    logic        upd_valid;
    logic [7:0]  upd_idx;
    logic [7:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_pred;
    logic        ready;
    logic        miss_predict;
    logic [15:0] miss_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [16:0] pred_q [$];
    logic [15:0] miss_q [$];

    gshare_bht dut (
        .clk(clk), .rst_i(rst),
        .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
        .pred_taken_o(pred_taken), .pred_idx_o(pred_idx), .pred_ghr_o(pred_ghr),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_ghr_i(upd_ghr),
        .upd_taken_i(upd_taken), .upd_pred_i(upd_pred),
        .ready_o(ready), .miss_predict_o(miss_predict), .miss_cnt_o(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1 && pred_valid) begin
            if (pred_q.size() == 0) begin
                check("pred_unexpected", 32'(pred_q.size()), 32'd1);
            end else begin
                logic [16:0] e;
                e = pred_q.pop_front();
                check("pred_taken", 32'(pred_taken), 32'(e[16]));
                check("pred_idx",   32'(pred_idx),   32'(e[15:8]));
                check("pred_ghr",   32'(pred_ghr),   32'(e[7:0]));
            end
        end
        if (miss_predict === 1'b1) begin
            if (miss_q.size() == 0) begin
                check("miss_unexpected", 32'(miss_predict), 32'd0);
            end else begin
                check("miss_cnt", 32'(miss_cnt), 32'(miss_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pexp(input bit t, input logic [7:0] idx, input logic [7:0] g);
        pred_q.push_back({t, idx, g});
    endtask

    task automatic step(input bit pv, input logic [31:0] pc,
                        input bit uv, input logic [7:0] ui, input logic [7:0] ug,
                        input bit ut, input bit up);
        pred_valid = pv; pred_pc = pc;
        upd_valid = uv; upd_idx = ui; upd_ghr = ug; upd_taken = ut; upd_pred = up;
        cyc();
        pred_valid = 1'b0; upd_valid = 1'b0;
    endtask

    task automatic sweep(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 400) begin
            cyc();
            n++;
        end
    endtask

    task automatic predict(input logic [31:0] pc, input bit t, input logic [7:0] idx, input logic [7:0] g);
        pexp(t, idx, g);
        step(1'b1, pc, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [7:0] idx, input bit t);
        step(1'b0, 32'h0, 1'b1, idx, 8'h0, t, t);
    endtask

    initial begin
        int n;
        rst = 1'b1; pred_valid = 1'b0; pred_pc = '0; upd_valid = 1'b0;
        upd_idx = '0; upd_ghr = '0; upd_taken = 1'b0; upd_pred = 1'b0;
        cyc();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_miss_predict", 32'(miss_predict), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);

        // Sweep with traffic on both ports: all of it must be ignored.
        rst = 1'b0;
        pred_valid = 1'b1; pred_pc = 32'h40;
        upd_valid = 1'b1; upd_idx = 8'h10; upd_ghr = 8'hFF; upd_taken = 1'b1; upd_pred = 1'b0;
        check("init_pred_taken", 32'(pred_taken), 32'd0);
        sweep(n);
        pred_valid = 1'b0; upd_valid = 1'b0;
        check("sweep_cycles", 32'(n), 32'd256);
        check("sweep_miss_cnt", 32'(miss_cnt), 32'd0);

        // Every entry weak not-taken, history stays zero.
        for (int i = 0; i < 256; i++) predict(32'(i) << 2, 1'b0, 8'(i), 8'h00);

        // Saturation on idx 0x10.
        repeat (3) update(8'h10, 1'b1);                 // 01->10->11->11
        predict(32'h40, 1'b1, 8'h10, 8'h00);            // ghr -> 01
        update(8'h10, 1'b1);                            // stays 11
        update(8'h10, 1'b0);                            // 10
        predict(32'h44, 1'b1, 8'h10, 8'h01);            // ghr -> 03
        repeat (3) update(8'h10, 1'b0);                 // 01, 00, 00
        update(8'h10, 1'b1);                            // 01
        predict(32'h4C, 1'b0, 8'h10, 8'h03);            // ghr -> 06
        update(8'h10, 1'b1);                            // 10
        predict(32'h58, 1'b1, 8'h10, 8'h06);            // ghr -> 0D

        // Mispredict restores ghr to {00[6:0],0}, then history shifting.
        miss_q.push_back(16'd1);
        step(1'b0, 32'h0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
        update(8'h20, 1'b1);
        update(8'h21, 1'b1);
        update(8'h23, 1'b1);
        predict(32'h80, 1'b1, 8'h20, 8'h00);
        predict(32'h80, 1'b1, 8'h21, 8'h01);
        predict(32'h80, 1'b1, 8'h23, 8'h03);
        predict(32'h80, 1'b0, 8'h27, 8'h07);            // ghr -> 0E

        // Mispredict with a same-cycle prediction: restore wins, ghr = 4A.
        pexp(1'b0, 8'h2E, 8'h0E);
        miss_q.push_back(16'd2);
        step(1'b1, 32'h80, 1'b1, 8'hFE, 8'hA5, 1'b0, 1'b1);
        predict(32'h0, 1'b0, 8'h4A, 8'h4A);

        // Mispredict counter saturation from FFFE.
        dut.miss_cnt = 16'hFFFE;
        repeat (3) begin
            miss_q.push_back(16'hFFFF);
            step(1'b0, 32'h0, 1'b1, 8'hFD, 8'h00, 1'b1, 1'b0);
        end
        cyc();
        check("miss_cnt_hold", 32'(miss_cnt), 32'hFFFF);
        check("miss_pulse_end", 32'(miss_predict), 32'd0);

        // Reset gates predictions immediately; entry 0x10 currently holds 10.
        rst = 1'b1;
        cyc();
        pred_valid = 1'b1; pred_pc = 32'h40;
        #1;
        check("init_gate_taken", 32'(pred_taken), 32'd0);
        check("init_gate_idx", 32'(pred_idx), 32'h10);
        check("rst2_miss_cnt", 32'(miss_cnt), 32'd0);
        check("rst2_ready", 32'(ready), 32'd0);
        pred_valid = 1'b0;

        // Reset again at ptr=100: the full sweep restarts.
        rst = 1'b0;
        repeat (100) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sweep(n);
        check("midsweep_cycles", 32'(n), 32'd256);
        predict(32'h40, 1'b0, 8'h10, 8'h00);
        cyc();

        check("pred_q_drained", 32'(pred_q.size()), 32'd0);
        check("miss_q_drained", 32'(miss_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
